inpdt_acc: RTL and testbench
============================

# inpdt_acc

Accumulation and output stage directly downstream of the 16-lane inner-product block. Consumes one 21-bit unsigned partial dot product per accepted beat and sums NUM_CHUNKS consecutive partials (plus an optional bias) into one LSTM gate pre-activation. The sum is right-shifted, saturated to OUT_W bits and presented on a one-entry valid/ready output register. It also drives the inner-product block's enable so that stage only toggles on accepted beats.

## Interface
- NUM_CHUNKS, 8, partials per dot product (1..256); 16-lane chunks per gate row
- IN_W, 21, partial width; equals inner-product output width
- ACC_W, 32, accumulator width; must be at least IN_W + clog2(NUM_CHUNKS) + 1
- SHIFT, 8, arithmetic right shift applied to the final sum (0..ACC_W-1)
- OUT_W, 16, result width

- iClk  in  1  clock; all state updates on rising edge
- iRstn  in  1  reset; asynchronous, active-low
- iValid  in  1  upstream partial valid
- oReady  out  1  stage can accept a partial this cycle
- iPartial  in  IN_W  unsigned partial (inner-product oResult)
- iBias  in  ACC_W  unsigned bias; sampled only on the first chunk of a row
- iClear  in  1  synchronous abort of the row in progress
- oEn  out  1  iValid & oReady; wired to the inner-product iEn
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oResult  out  OUT_W  saturated, shifted sum
- oSat  out  1  saturation occurred for the held result

## Operation
- States: IDLE, ACCUM, OUT.
- Reset values: state=IDLE, cnt=0, acc=0, oValid=0, oResult=0, oSat=0.
- Accept condition: iValid & oReady.
- oReady is 1 in IDLE and ACCUM. In OUT it equals iReady, so a new row can start in the same cycle the result drains.
- First chunk (IDLE, or accepted in OUT):
  - acc <= bias + iPartial, where bias = iBias or 0 (see Configuration).
  - cnt <= 1.
  - Next state is ACCUM; it is OUT directly when NUM_CHUNKS=1.
- ACCUM accept: acc <= acc + iPartial, cnt <= cnt + 1.
- When the accepted chunk is chunk NUM_CHUNKS:
  - oResult <= min(sum >> SHIFT, 2^OUT_W - 1), where sum is the final acc value.
  - oSat <= 1 if clamped, otherwise 0.
  - oValid <= 1 and state <= OUT.
- Arithmetic is unsigned and never wraps: ACC_W sizing guarantees this. The shift truncates (no rounding).
- OUT with iReady=0: oValid, oResult and oSat hold stable; no partial is accepted.
- OUT with iReady=1 and no accepted partial: oValid <= 0 and state goes to IDLE.
- iClear has priority over any accept in the same cycle:
  - cnt <= 0, acc <= 0, state <= IDLE.
  - If it arrives in OUT, the pending result is dropped and oValid <= 0.
  - The partial presented in that cycle is discarded.
- Asserting iRstn low mid-row immediately returns every register to its reset value.

## Timing
- Latency: oValid rises the cycle after the final chunk is accepted.
- Throughput: one partial per cycle, with no bubble between rows when iReady=1.
- A row of NUM_CHUNKS chunks yields one result every NUM_CHUNKS cycles.
- oEn is combinational from iValid, state and iReady. All other outputs are registered.
- oResult is never updated while oValid=1 and iReady=0.

## Configuration
- INPDT_ACC_BIAS_EN:
  - Defined: the first chunk loads iBias + iPartial.
  - Undefined: the first chunk loads iPartial only. iBias is ignored (left unconnected internally), and the bias adder is removed.

## Test plan
All scenarios use NUM_CHUNKS=4, SHIFT=8, OUT_W=16, ACC_W=32 and iReady=1 unless stated.
- Basic: bias 0, partials 1000, 2000, 3000, 4000 on consecutive cycles -> oValid one cycle after the 4th accept; oResult=39 (10000>>8); oSat=0.
- Saturation (macro on): iBias=16777216, four partials of 0 -> oResult=65535, oSat=1.
- Backpressure: hold iReady=0 for 5 cycles after oValid -> oResult and oValid stable and oReady=0. Then raise iReady with iValid=1 -> result drains and the partial is accepted as chunk 1 in the same cycle.
- Abort: two partials of 9999, then iClear=1 together with iValid=1 -> that partial is discarded. Next four partials of 256 -> oResult=4.
- Reset mid-row: drop iRstn after chunk 2 -> oValid=0, oResult=0, oSat=0 asynchronously. After release, a fresh row computes correctly.
- Macro off: iBias=500, partials 256 ×4 -> oResult=4 (bias ignored). With the macro on, the same stimulus gives 5 (1524>>8).

Source files
------------

// File: rtl/inpdt_acc.sv
// Accumulates NUM_CHUNKS inner-product partials into one gate pre-activation, then shifts, saturates and holds it.
// Optional bias on the first chunk of each row is enabled by defining INPDT_ACC_BIAS_EN.
module inpdt_acc #(
    parameter int NUM_CHUNKS = 8,
    parameter int IN_W       = 21,
    parameter int ACC_W      = 32,
    parameter int SHIFT      = 8,
    parameter int OUT_W      = 16
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iValid,
    output logic             oReady,
    input  logic [IN_W-1:0]  iPartial,
    input  logic [ACC_W-1:0] iBias,
    input  logic             iClear,
    output logic             oEn,
    output logic             oValid,
    input  logic             iReady,
    output logic [OUT_W-1:0] oResult,
    output logic             oSat
);
    localparam int CNT_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [ACC_W-1:0] MAX_OUT  = ACC_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   result_q, result_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic               first_chunk;
    logic               last_chunk;
    logic [ACC_W-1:0]   bias_val;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   shifted;
    logic               clamp;

`ifdef INPDT_ACC_BIAS_EN
    assign bias_val = iBias;
`else
    logic unused_bias;
    assign unused_bias = ^iBias;
    assign bias_val    = '0;
`endif

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A row starts from IDLE, or from OUT when the held result drains in the same cycle.
    always_comb begin
        first_chunk = (state_q != ACCUM);
        last_chunk  = first_chunk ? (NUM_CHUNKS == 1) : (cnt_q == LAST_CNT);
        state_d     = state_q;
        if (iClear) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = last_chunk ? OUT : ACCUM;
        end else if (state_q == OUT && iReady) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        oReady = (state_q != OUT) | iReady;
        oEn    = iValid & oReady;
        accept = oEn;
    end

    always_comb begin
        acc_sum  = (first_chunk ? bias_val : acc_q) + ACC_W'(iPartial);
        shifted  = acc_sum >> SHIFT;
        clamp    = (shifted > MAX_OUT);

        cnt_d    = cnt_q;
        acc_d    = acc_q;
        valid_d  = valid_q;
        result_d = result_q;
        sat_d    = sat_q;

        if (iClear) begin
            cnt_d   = '0;
            acc_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            acc_d   = acc_sum;
            cnt_d   = first_chunk ? CNT_W'(1) : CNT_W'(cnt_q + 1'b1);
            valid_d = last_chunk;
            if (last_chunk) begin
                result_d = clamp ? '1 : OUT_W'(shifted);
                sat_d    = clamp;
            end
        end else if (state_q == OUT && iReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oSat    = sat_q;

endmodule

// File: tb/tb_inpdt_acc.sv
// Directed bench for inpdt_acc: row-level scoreboard model checked every cycle plus hand-computed literals.
`timescale 1ns/1ps
module tb_inpdt_acc;
    localparam int N     = 4;
    localparam int IN_W  = 21;
    localparam int ACC_W = 32;
    localparam int SHIFT = 8;
    localparam int OUT_W = 16;
`ifdef INPDT_ACC_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic             iClk = 1'b0;
    logic             iRstn = 1'b1;
    logic             iValid = 1'b0;
    logic             oReady;
    logic [IN_W-1:0]  iPartial = '0;
    logic [ACC_W-1:0] iBias = '0;
    logic             iClear = 1'b0;
    logic             oEn;
    logic             oValid;
    logic             iReady = 1'b1;
    logic [OUT_W-1:0] oResult;
    logic             oSat;

    inpdt_acc #(.NUM_CHUNKS(N), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .iClk(iClk), .iRstn(iRstn), .iValid(iValid), .oReady(oReady),
        .iPartial(iPartial), .iBias(iBias), .iClear(iClear), .oEn(oEn),
        .oValid(oValid), .iReady(iReady), .oResult(oResult), .oSat(oSat)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Row-level model: a result is pending or not; partials of the open row sit in a queue.
    bit     m_pend = 1'b0;
    longint m_res  = 0;
    bit     m_sat  = 1'b0;
    longint m_bias = 0;
    longint m_row[$];

    function automatic bit m_ready();
        return !m_pend || iReady;
    endfunction

    initial begin
        longint sum;
        longint q;
        forever begin
            @(posedge iClk or negedge iRstn);
            if (!iRstn) begin
                m_pend = 1'b0; m_res = 0; m_sat = 1'b0; m_row.delete();
            end else if (iClear) begin
                m_row.delete(); m_pend = 1'b0;
            end else if (iValid && m_ready()) begin
                if (m_row.size() == 0) m_bias = BIAS_ON ? longint'(iBias) : 0;
                m_row.push_back(longint'(iPartial));
                if (m_row.size() == N) begin
                    sum = m_bias;
                    foreach (m_row[k]) sum += m_row[k];
                    q = sum / (longint'(1) << SHIFT);
                    m_sat = (q > 65535);
                    m_res = m_sat ? 65535 : q;
                    m_pend = 1'b1;
                    m_row.delete();
                    $display("row done: sum=%0d result=%0d sat=%0d", sum, m_res, m_sat);
                end else begin
                    m_pend = 1'b0;
                end
            end else if (m_pend && iReady) begin
                m_pend = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            check("cyc_valid", oValid, m_pend);
            check("cyc_ready", oReady, m_ready());
            check("cyc_en", oEn, iValid && m_ready());
            check("cyc_result", oResult, m_res);
            check("cyc_sat", oSat, m_sat);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic beat(input longint p);
        iValid   = 1'b1;
        iPartial = IN_W'(p);
        step();
    endtask

    task automatic idle();
        iValid   = 1'b0;
        iPartial = '0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!oValid && k < budget) begin
            step();
            k++;
        end
        if (!oValid) check("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        #1 iRstn = 1'b0;
        #2;
        check("rst_valid", oValid, 0);
        check("rst_result", oResult, 0);
        check("rst_sat", oSat, 0);
        check("rst_ready", oReady, 1);
        @(posedge iClk); #1 iRstn = 1'b1;
        step();

        // Basic row and latency
        beat(1000); beat(2000); beat(3000);
        check("lat_valid_early", oValid, 0);
        beat(4000);
        check("basic_valid", oValid, 1);
        check("basic_result", oResult, 39);
        check("basic_sat", oSat, 0);

        // Back-to-back row, no bubble
        beat(2560);
        check("b2b_drain", oValid, 0);
        beat(2560); beat(2560); beat(2560);
        check("b2b_result", oResult, 40);
        idle(); step();

        // Backpressure
        beat(512); beat(512); beat(512); beat(512);
        idle();
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", oValid, 1);
            check("bp_result", oResult, 8);
            check("bp_ready", oReady, 0);
        end
        iReady   = 1'b1;
        iValid   = 1'b1;
        iPartial = 256;
        #1;
        check("bp_release_ready", oReady, 1);
        check("bp_release_en", oEn, 1);
        step();
        check("bp_drained", oValid, 0);
        beat(256); beat(256); beat(256);
        check("bp_chunk1_valid", oValid, 1);
        check("bp_chunk1_result", oResult, 4);
        idle(); step();

        // Abort
        beat(9999); beat(9999);
        iClear = 1'b1;
        beat(9999);
        iClear = 1'b0;
        beat(256); beat(256); beat(256); beat(256);
        check("abort_result", oResult, 4);
        check("abort_valid", oValid, 1);
        idle(); step();

        // Asynchronous reset mid-row
        beat(1000); beat(2000);
        idle();
        #2 iRstn = 1'b0;
        #1;
        check("rst2_valid", oValid, 0);
        check("rst2_result", oResult, 0);
        check("rst2_sat", oSat, 0);
        @(posedge iClk); #1 iRstn = 1'b1;
        beat(1000); beat(2000); beat(3000); beat(4000);
        check("post_rst_result", oResult, 39);
        idle(); step();

        // Bias sampled only on the first chunk
        iBias = 500;
        beat(256);
        iBias = 99999;
        beat(256); beat(256); beat(256);
        check("bias_result", oResult, BIAS_ON ? 5 : 4);
        iBias = 0;
        idle(); step();

        // Largest partials without saturation
        beat(2097151); beat(2097151); beat(2097151); beat(2097151);
        idle();
        wait_valid(8);
        check("max_result", oResult, 32767);
        check("max_sat", oSat, 0);
        step();

`ifdef INPDT_ACC_BIAS_EN
        iBias = 16777216;
        beat(0);
        iBias = 0;
        beat(0); beat(0); beat(0);
        check("sat_result", oResult, 65535);
        check("sat_flag", oSat, 1);
        idle(); step();
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
